// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core's pipeline registers and the stall/flush/redirect sequencer.
// master = pipeline side (raises requests, consumes controls); slave = pipeline_ctrl.
`timescale 1ns/1ps
interface pipeline_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              stallreq_if;
   logic              stallreq_id;
   logic              stallreq_ex;
   logic              stallreq_mem;
   logic              br;
   logic [ADDR_W-1:0] br_addr;
   logic              halt_req;
   logic              resume;
   logic [5:0]        stall;
   logic              flush_if_id;
   logic              redirect_vld;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;
   logic              wdog_timeout;

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output br, br_addr, halt_req, resume,
      input  stall, flush_if_id, redirect_vld, redirect_pc, halted, wdog_timeout
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  br, br_addr, halt_req, resume,
      output stall, flush_if_id, redirect_vld, redirect_pc, halted, wdog_timeout
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the five-stage core, including the halt/drain/resume FSM.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
`timescale 1ns/1ps
module pipeline_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int WDOG_LIMIT   = 1024,
   parameter int WDOG_W       = 16
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              pend_vld;
   logic [ADDR_W-1:0] pend_pc;

   logic [5:0]        base;
   logic [5:0]        stall_c;
   logic              id_adv;
   logic              pend_issue;
   logic              br_take;
   logic              direct;
   logic              capture;
   logic              flush_c;
   logic              redir_c;
   logic [ADDR_W-1:0] redir_pc_c;

   always_comb begin
      base       = 6'b000000;
      stall_c    = 6'b000000;
      id_adv     = 1'b0;
      pend_issue = 1'b0;
      br_take    = 1'b0;
      direct     = 1'b0;
      capture    = 1'b0;
      flush_c    = 1'b0;
      redir_c    = 1'b0;
      redir_pc_c = '0;

      if (bus.stallreq_mem)      base = 6'b011111;
      else if (bus.stallreq_ex)  base = 6'b001111;
      else if (bus.stallreq_id)  base = 6'b000111;
      else if (bus.stallreq_if)  base = 6'b000011;

      case (state)
         RUN:     stall_c = base;
         DRAIN:   stall_c = base | 6'b000011;
         default: stall_c = 6'b000011;
      endcase

      id_adv = ~stall_c[2];

      if (state == RUN) begin
         pend_issue = pend_vld & ~stall_c[0];
         // A branch seen alongside a halt is parked so it issues after resume.
         br_take    = bus.br & id_adv & ~pend_vld;
         direct     = br_take & ~stall_c[0] & ~bus.halt_req;
         capture    = br_take & (stall_c[0] | bus.halt_req);
         flush_c    = pend_issue | direct | capture;
         redir_c    = pend_issue | direct;
         redir_pc_c = pend_issue ? pend_pc : bus.br_addr;
      end else begin
         flush_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= RUN;
         cnt      <= '0;
         pend_vld <= 1'b0;
         pend_pc  <= '0;
      end else begin
         case (state)
            RUN: begin
               if (pend_issue) pend_vld <= 1'b0;
               if (capture) begin
                  pend_vld <= 1'b1;
                  pend_pc  <= bus.br_addr;
               end
               if (bus.halt_req && id_adv) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end
            end
            DRAIN: begin
               // Drain progress only counts cycles where EX/MEM actually advance.
               if (!stall_c[3] && !stall_c[4]) begin
                  if (cnt == CNT_LAST) state <= HALTED;
                  else                 cnt   <= cnt + 1'b1;
               end
            end
            HALTED: begin
               if (bus.resume) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.stall        = rst ? stall_c : 6'b000000;
   assign bus.flush_if_id  = rst & flush_c;
   assign bus.redirect_vld = rst & redir_c;
   assign bus.redirect_pc  = rst ? redir_pc_c : '0;
   assign bus.halted       = rst & (state == HALTED);

`ifdef STALL_WATCHDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_LIMIT);
   localparam logic [WDOG_W-1:0] WDOG_PREV = WDOG_W'(WDOG_LIMIT - 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_flag;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_cnt  <= '0;
         wdog_flag <= 1'b0;
      end else if (state == RUN) begin
         if (stall_c != 6'b000000) begin
            if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_PREV || wdog_cnt == WDOG_MAX) wdog_flag <= 1'b1;
         end else begin
            wdog_cnt <= '0;
         end
      end
   end

   assign bus.wdog_timeout = rst & wdog_flag;
`else
   // Watchdog parameters remain part of the interface even when the counter is not built.
   localparam logic WDOG_FITS = ((64'(WDOG_LIMIT) >> WDOG_W) == 64'd0);
   assign bus.wdog_timeout = 1'b0 & WDOG_FITS;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pipeline_ctrl;

   localparam int DRAIN = 3;
   localparam int WLIM  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipeline_ctrl_if #(.ADDR_W(32)) bus ();

   pipeline_ctrl #(
      .ADDR_W(32), .DRAIN_CYCLES(DRAIN), .WDOG_LIMIT(WLIM), .WDOG_W(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic        rvld;
      logic [31:0] rpc;
      logic        rpc_care;
      logic        halted;
      logic        wdog;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model state: mode 0=running, 1=draining, 2=halted.
   int          m_mode  = 0;
   int          m_left  = DRAIN;
   bit          m_pend  = 0;
   logic [31:0] m_ppc   = '0;
   int          m_wcnt  = 0;
   bit          m_wflag = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("stall",        32'(bus.stall),        32'(e.stall));
         chk("flush_if_id",  32'(bus.flush_if_id),  32'(e.flush));
         chk("redirect_vld", 32'(bus.redirect_vld), 32'(e.rvld));
         if (e.rpc_care) chk("redirect_pc", bus.redirect_pc, e.rpc);
         chk("halted",       32'(bus.halted),       32'(e.halted));
         chk("wdog_timeout", 32'(bus.wdog_timeout), 32'(e.wdog));
         cyc++;
      end
   end

   task automatic step(input bit r, input bit sif, input bit sid, input bit sex, input bit smem,
                       input bit b, input logic [31:0] ba, input bit h, input bit res);
      exp_t e;
      int   depth;
      bit   id_adv;
      rst              = r;
      bus.stallreq_if  = sif;
      bus.stallreq_id  = sid;
      bus.stallreq_ex  = sex;
      bus.stallreq_mem = smem;
      bus.br           = b;
      bus.br_addr      = ba;
      bus.halt_req     = h;
      bus.resume       = res;

      e.stall = '0; e.flush = 0; e.rvld = 0; e.rpc = '0; e.rpc_care = 0; e.halted = 0; e.wdog = 0;
      if (!r) begin
         e.rpc_care = 1;
         m_mode = 0; m_left = DRAIN; m_pend = 0; m_ppc = '0; m_wcnt = 0; m_wflag = 0;
      end else begin
         // Stall covers every stage up to and including the deepest requester.
         depth = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
         e.stall = 6'((1 << depth) - 1);
         if (m_mode != 0) e.stall = e.stall | 6'b000011;
         if (m_mode == 2) e.stall = 6'b000011;
         e.wdog = m_wflag;
         id_adv = !e.stall[2];
         if (m_mode == 0) begin
            if (e.stall != 0) begin
               if (m_wcnt < WLIM) m_wcnt++;
`ifdef STALL_WATCHDOG_EN
               if (m_wcnt >= WLIM) m_wflag = 1;
`endif
            end else m_wcnt = 0;
            if (m_pend && !e.stall[0]) begin
               e.rvld = 1; e.rpc = m_ppc; e.rpc_care = 1; e.flush = 1; m_pend = 0;
            end else if (b && id_adv && !m_pend) begin
               e.flush = 1;
               if (h || e.stall[0]) begin m_pend = 1; m_ppc = ba; end
               else begin e.rvld = 1; e.rpc = ba; e.rpc_care = 1; end
            end
            if (h && id_adv) begin m_mode = 1; m_left = DRAIN; end
         end else if (m_mode == 1) begin
            e.flush = 1;
            if (!e.stall[3]) m_left--;
            if (m_left == 0) m_mode = 2;
         end else begin
            e.flush = 1; e.halted = 1;
            if (res) m_mode = 0;
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
      bus.br = 0; bus.br_addr = '0; bus.halt_req = 0; bus.resume = 0;
      @(posedge clk);
      #1;
      step(0, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 1, 1);
      step(0, 0, 0, 0, 0, 0, '0, 0, 0);
      idle(2);

      // Stall priority
      step(1, 0, 1, 0, 1, 0, '0, 0, 0);
      step(1, 1, 0, 0, 0, 0, '0, 0, 0);
      step(1, 1, 1, 1, 0, 0, '0, 0, 0);
      // Direct branch
      step(1, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 0);
      idle(1);
      // Pending branch held across an IF stall
      step(1, 1, 0, 0, 0, 1, 32'h0000_0200, 0, 0);
      step(1, 1, 0, 0, 0, 0, '0, 0, 0);
      step(1, 1, 0, 0, 0, 0, '0, 0, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 0);
      idle(2);
      // Halt with MEM stall extending the drain, then resume
      step(1, 0, 0, 0, 0, 0, '0, 1, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 0);
      step(1, 0, 0, 0, 1, 0, '0, 0, 0);
      step(1, 0, 0, 0, 1, 0, '0, 0, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 1);
      step(1, 0, 0, 0, 0, 0, '0, 0, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 1);
      idle(2);
      // Halt together with a branch, then reset mid-drain with the branch pending
      step(1, 0, 0, 0, 0, 1, 32'h0000_0300, 1, 0);
      step(1, 0, 0, 0, 0, 0, '0, 0, 0);
      step(0, 0, 0, 0, 0, 0, '0, 0, 0);
      step(0, 1, 0, 0, 1, 1, 32'h0000_0400, 1, 1);
      idle(4);
      // Long EX stall for the watchdog
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, 0, '0, 0, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, '0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         bit b;
         b = ($urandom_range(0, 3) == 0) && !m_pend;
         step($urandom_range(0, 59) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              b, $urandom, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
      end

      repeat (3) @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
